// File: rtl/mcm_pkg.sv
// mcm_pkg: shared constants and helpers for the two-constant multiplier
// consumer path (y[n] = 974*x[n] + 25*x[n-1]).
//   C0, C1        : the two multiplier constants of the upstream block
//   X_W           : width of the raw sample x feeding the upstream block
//   *_DEF         : default widths of the product inputs and of the output
//   min_out_w()   : smallest signed width that holds the worst-case y
package mcm_pkg;

  localparam int C0 = 974;
  localparam int C1 = 25;
  localparam int X_W = 8;

  localparam int P0_W_DEF  = 18;
  localparam int P1_W_DEF  = 13;
  localparam int OUT_W_DEF = 19;

  // Worst case is every tap seeing the same extreme x, so the output
  // range is x_extreme * (c0 + c1). Constants are assumed non-negative.
  function automatic int min_out_w(input int xw, input int c0, input int c1);
    longint lo;
    longint hi;
    int     w;
    lo = -(longint'(1) <<< (xw - 1)) * longint'(c0 + c1);
    hi = ((longint'(1) <<< (xw - 1)) - 1) * longint'(c0 + c1);
    w  = 1;
    while ((w < 63) &&
           ((lo < -(longint'(1) <<< (w - 1))) ||
            (hi > ((longint'(1) <<< (w - 1)) - 1))))
      w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/mcm_fir2_accum_valid_delay.sv
// valid_delay: DEPTH-stage shift register for a 1-bit valid flag.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears all stages
//   flush : synchronous flush, clears all stages (including the bit
//           being shifted in this cycle)
//   d     : flag entering the pipe
//   q     : flag leaving the pipe, DEPTH cycles after d
module valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  // Stage-by-stage shift keeps DEPTH == 1 legal without special slicing.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/mcm_fir2_accum.sv
// mcm_fir2_accum: 2-tap transposed FIR y[n] = 974*x[n] + 25*x[n-1] built
// from the registered products of the upstream constant multiplier block,
// with the sample stream cut into frames of FRAME_LEN samples. Filter state
// is cleared at every frame boundary, so each frame starts with 974*x only.
//   clk, rst   : clock and synchronous active-high reset
//   in_valid   : x is presented to the upstream multiplier this cycle
//   clear      : synchronous flush of in-flight samples, state and counter
//   X_974      : signed 974*x, arriving MULT_LAT cycles after in_valid
//   X_25       : signed 25*x, same timing as X_974
//   y          : registered signed filter output
//   y_valid    : one-cycle pulse per output sample
//   y_last     : qualifies y_valid, marks the final sample of a frame
//   frame_cnt  : samples consumed in the current frame
//
// Handshake: valid-only streaming, there is no ready. A sample enters when
// in_valid is high and leaves exactly MULT_LAT+1 cycles later as a one-cycle
// y_valid pulse; y_last is meaningful only while y_valid is high. Full-rate
// input gives full-rate output.
module mcm_fir2_accum
  import mcm_pkg::*;
#(
  parameter int MULT_LAT  = 1,
  parameter int P0_W      = P0_W_DEF,
  parameter int P1_W      = P1_W_DEF,
  parameter int OUT_W     = OUT_W_DEF,
  parameter int FRAME_LEN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             clear,
  input  logic [P0_W-1:0]  X_974,
  input  logic [P1_W-1:0]  X_25,
  output logic [OUT_W-1:0] y,
  output logic             y_valid,
  output logic             y_last,
  output logic [15:0]      frame_cnt
);

  // Elaboration-time parameter checks. The adder can grow one bit past its
  // widest operand, so OUT_W must also exceed P0_W, not only the range
  // reachable from 8-bit x.
  if (OUT_W < min_out_w(X_W, C0, C1)) begin : g_bad_out_range
    $error("mcm_fir2_accum: OUT_W too small for worst-case output");
  end
  if (OUT_W < P0_W + 1 || OUT_W < P1_W + 1) begin : g_bad_out_growth
    $error("mcm_fir2_accum: OUT_W must exceed both product widths");
  end
  if (MULT_LAT < 1 || MULT_LAT > 4) begin : g_bad_lat
    $error("mcm_fir2_accum: MULT_LAT out of range 1..4");
  end
  if (FRAME_LEN < 2 || FRAME_LEN > 65535) begin : g_bad_len
    $error("mcm_fir2_accum: FRAME_LEN out of range 2..65535");
  end

  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  // pv is high exactly when X_974/X_25 carry products of a valid x.
  logic pv;

  valid_delay #(
    .DEPTH (MULT_LAT)
  ) u_valid_delay (
    .clk   (clk),
    .rst   (rst),
    .flush (clear),
    .d     (in_valid),
    .q     (pv)
  );

  logic signed [P0_W-1:0]  p0;
  logic signed [P1_W-1:0]  p1;
  logic signed [P1_W-1:0]  z;
  logic signed [OUT_W-1:0] sum;
  logic                    at_last;

  assign p0 = X_974;
  assign p1 = X_25;

  // Size casts of signed operands sign-extend before the add.
  assign sum     = OUT_W'(p0) + OUT_W'(z);
  assign at_last = (frame_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      y         <= '0;
      y_valid   <= 1'b0;
      y_last    <= 1'b0;
      frame_cnt <= '0;
      z         <= '0;
    end else if (pv) begin
      y       <= sum;
      y_valid <= 1'b1;
      if (at_last) begin
        // Frame boundary: the next frame must not see this sample.
        z         <= '0;
        frame_cnt <= '0;
        y_last    <= 1'b1;
      end else begin
        z         <= p1;
        frame_cnt <= frame_cnt + 16'd1;
        y_last    <= 1'b0;
      end
    end else begin
      // Idle cycle: state and y hold so input gaps are harmless.
      y_valid <= 1'b0;
      y_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mcm_fir2_accum.sv
// Bench for mcm_fir2_accum (MULT_LAT=1, FRAME_LEN=4). The upstream
// multiplier is emulated by the driver: products of the sample issued in
// one cycle are presented in the next; in other cycles products are random.
module tb_mcm_fir2_accum;

  localparam int ML   = 1;
  localparam int L    = 4;
  localparam int OW   = 19;
  localparam int P0W  = 18;
  localparam int P1W  = 13;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic clear = 1'b0;
  logic [P0W-1:0] X_974 = '0;
  logic [P1W-1:0] X_25 = '0;
  logic [OW-1:0]  y;
  logic           y_valid;
  logic           y_last;
  logic [15:0]    frame_cnt;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  mcm_fir2_accum #(
    .MULT_LAT  (ML),
    .P0_W      (P0W),
    .P1_W      (P1W),
    .OUT_W     (OW),
    .FRAME_LEN (L)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .clear     (clear),
    .X_974     (X_974),
    .X_25      (X_25),
    .y         (y),
    .y_valid   (y_valid),
    .y_last    (y_last),
    .frame_cnt (frame_cnt)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    int y;
    bit last;
    int fc;
    int due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Reference model: position in frame and previous sample of this frame.
  int pos = 0;
  int prevx = 0;
  bit pend_v = 1'b0;
  int pend_x = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit v, input int x, input bit clr, input bit rs);
    int ye;
    bit le;
    @(negedge clk);
    if (pend_v) begin
      X_974 = P0W'(974 * pend_x);
      X_25  = P1W'(25 * pend_x);
    end else begin
      X_974 = P0W'($urandom);
      X_25  = P1W'($urandom);
    end
    in_valid = v;
    clear    = clr;
    rst      = rs;
    pend_v   = v && !clr && !rs;
    pend_x   = x;
    if (clr || rs) begin
      // Anything that would emerge after this cycle is discarded.
      while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
      pos   = 0;
      prevx = 0;
    end else if (v) begin
      ye = 974 * x + ((pos > 0) ? 25 * prevx : 0);
      le = (pos == L - 1);
      pos   = le ? 0 : pos + 1;
      prevx = x;
      exp_q.push_back('{y: ye, last: le, fc: pos, due: cyc + ML + 1});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    @(posedge clk);
    #2;
    chk({tag, "_y"}, int'($signed(y)), 0);
    chk({tag, "_y_valid"}, int'(y_valid), 0);
    chk({tag, "_y_last"}, int'(y_last), 0);
    chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (y_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got y=%0d last=%0d at cycle %0d, expected none",
                 $signed(y), y_last, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.due != cyc || int'($signed(y)) != mon_e.y ||
            y_last !== mon_e.last || int'(frame_cnt) != mon_e.fc) begin
          errors++;
          $display("FAIL sample: got y=%0d last=%0d fc=%0d cyc=%0d, expected y=%0d last=%0d fc=%0d cyc=%0d",
                   $signed(y), y_last, frame_cnt, cyc, mon_e.y, mon_e.last, mon_e.fc, mon_e.due);
        end
      end
    end else begin
      chk("y_last_idle", int'(y_last), 0);
    end
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_output: got nothing, expected y=%0d at cycle %0d",
               exp_q[0].y, exp_q[0].due);
      void'(exp_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0);
    check_zero("reset");

    // Impulse: 974, 25, 0
    step(1'b1, 1, 1'b0, 1'b0);
    step(1'b1, 0, 1'b0, 1'b0);
    step(1'b1, 0, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 0, 1'b1, 1'b0);

    // Ramp: 974, 1973
    step(1'b1, 1, 1'b0, 1'b0);
    step(1'b1, 2, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 0, 1'b1, 1'b0);

    // Extremes
    step(1'b1, -128, 1'b0, 1'b0);
    step(1'b1, -128, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b1, 127, 1'b0, 1'b0);
    step(1'b1, 127, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 0, 1'b1, 1'b0);

    // Two full frames of x=1
    for (int i = 0; i < 2 * L; i++) step(1'b1, 1, 1'b0, 1'b0);
    idle(3);
    chk("frame_cnt_after_frames", int'(frame_cnt), 0);

    // Gapped input: 1948, then 1024
    step(1'b1, 2, 1'b0, 1'b0);
    idle(3);
    chk("frame_cnt_in_gap", int'(frame_cnt), 1);
    step(1'b1, 1, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 0, 1'b1, 1'b0);

    // Clear with one sample in flight
    step(1'b1, 5, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    check_zero("clear");
    step(1'b1, 1, 1'b0, 1'b0);
    idle(3);

    // Reset mid-frame
    step(1'b1, 3, 1'b0, 1'b0);
    step(1'b1, 4, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1);
    check_zero("mid_reset");
    step(1'b0, 0, 1'b0, 1'b0);

    // Randomized traffic with occasional clear / reset
    for (int i = 0; i < 400; i++) begin
      bit v;
      bit c;
      bit r;
      int x;
      v = ($urandom_range(0, 3) != 0);
      x = int'($urandom_range(0, 255)) - 128;
      c = ($urandom_range(0, 49) == 0);
      r = ($urandom_range(0, 99) == 0);
      step(v, x, c, r);
    end

    idle(5);
    @(posedge clk);
    #2;
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
